// File: rtl/tank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tank_pkg
// Description : Shared types, game-state codes and grid-step helpers for the
//               tank game (used by shell_pool, shell_slot and tank).
// Revision    : 1.0 - initial parametrised shell store
// ============================================================================
package tank_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,   // y - 1
        DIR_DOWN  = 2'd1,   // y + 1
        DIR_LEFT  = 2'd2,   // x - 1
        DIR_RIGHT = 2'd3    // x + 1
    } dir_t;

    localparam logic [1:0] GS_INIT = 2'd0;
    localparam logic [1:0] GS_PLAY = 2'd1;
    localparam logic [1:0] GS_END  = 2'd2;

    // True when a one-cell step from (x,y) in dir stays inside 0..max.
    function automatic logic step_ok(input int x, input int y, input logic [1:0] dir,
                                     input int max_x, input int max_y);
        logic ok;
        case (dir)
            DIR_UP:   ok = (y > 0);
            DIR_DOWN: ok = (y < max_y);
            DIR_LEFT: ok = (x > 0);
            default:  ok = (x < max_x);
        endcase
        return ok;
    endfunction

    function automatic int next_x(input int x, input logic [1:0] dir);
        int r;
        case (dir)
            DIR_LEFT:  r = x - 1;
            DIR_RIGHT: r = x + 1;
            default:   r = x;
        endcase
        return r;
    endfunction

    function automatic int next_y(input int y, input logic [1:0] dir);
        int r;
        case (dir)
            DIR_UP:   r = y - 1;
            DIR_DOWN: r = y + 1;
            default:  r = y;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shell_slot.sv
`default_nettype none
// ============================================================================
// Module      : shell_slot
// Description : One shell slot: valid/x/y/dir registers with clear, vanish,
//               load and move handling (priority clear > vanish > load > move).
// Ports       : clk, rst_n       - clock, async active-low reset
//               i_clear          - synchronous wipe (game not in play)
//               i_vanish         - free this slot (ignored if already free)
//               i_load, i_load_* - claim slot with spawn position/direction
//               i_tick           - advance one cell if live
//               o_valid, o_x, o_y- registered slot state
//               o_valid_nxt      - next-cycle valid, for registered counters
// Revision    : 1.0 - initial
// ============================================================================
module shell_slot
    import tank_pkg::*;
#(
    parameter int COORD_W   = 6,
    parameter int MAP_X_MAX = 39,
    parameter int MAP_Y_MAX = 29
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_vanish,
    input  logic               i_load,
    input  logic [COORD_W-1:0] i_load_x,
    input  logic [COORD_W-1:0] i_load_y,
    input  logic [1:0]         i_load_dir,
    input  logic               i_tick,
    output logic               o_valid,
    output logic               o_valid_nxt,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y
);

    logic               r_valid;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [1:0]         r_dir;

    logic               w_valid_nxt;
    logic [COORD_W-1:0] w_x_nxt;
    logic [COORD_W-1:0] w_y_nxt;
    logic [1:0]         w_dir_nxt;

    always_comb begin
        w_valid_nxt = r_valid;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_dir_nxt   = r_dir;
        if (i_clear) begin
            w_valid_nxt = 1'b0;
            w_x_nxt     = '0;
            w_y_nxt     = '0;
            w_dir_nxt   = DIR_UP;
        end else if (i_vanish && r_valid) begin
            w_valid_nxt = 1'b0;
        end else if (i_load) begin
            w_valid_nxt = 1'b1;
            w_x_nxt     = i_load_x;
            w_y_nxt     = i_load_y;
            w_dir_nxt   = i_load_dir;
        end else if (i_tick && r_valid) begin
            // A shell about to leave the map is retired in place rather than wrapped.
            if (step_ok(int'(r_x), int'(r_y), r_dir, MAP_X_MAX, MAP_Y_MAX)) begin
                w_x_nxt = COORD_W'(next_x(int'(r_x), r_dir));
                w_y_nxt = COORD_W'(next_y(int'(r_y), r_dir));
            end else begin
                w_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_dir   <= DIR_UP;
        end else begin
            r_valid <= w_valid_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    assign o_valid     = r_valid;
    assign o_valid_nxt = w_valid_nxt;
    assign o_x         = r_x;
    assign o_y         = r_y;

endmodule
`default_nettype wire

// File: rtl/shell_pool.sv
`default_nettype none
// ============================================================================
// Module      : shell_pool
// Description : N_PLAYERS x SHELLS_PER_PLAYER shell store. Allocates the
//               lowest free slot on fire, moves shells on frame tick, frees
//               them on edge exit or vanish, and offers a registered read port.
// Ports       : clk, rst_n           - clock, async active-low reset
//               i_game_state         - slots only live in GS_PLAY
//               i_frame_tick, i_fire - move strobe, per-player fire pulses
//               i_tank_x/y/dir       - packed per-player tank pose
//               i_vanish             - per-slot free request
//               i_rd_player/slot     - read-port select
//               o_valid/o_x/o_y      - flat slot buses
//               o_count, o_drop      - per-player live count, fire-reject pulse
//               o_rd_valid/x/y       - read-port data, one cycle after select
// Revision    : 1.0 - initial
// ============================================================================
module shell_pool
    import tank_pkg::*;
#(
    parameter int N_PLAYERS         = 2,
    parameter int SHELLS_PER_PLAYER = 5,
    parameter int COORD_W           = 6,
    parameter int MAP_X_MAX         = 39,
    parameter int MAP_Y_MAX         = 29,
    localparam int c_NS = N_PLAYERS * SHELLS_PER_PLAYER,
    localparam int c_PW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1,
    localparam int c_SW = (SHELLS_PER_PLAYER > 1) ? $clog2(SHELLS_PER_PLAYER) : 1,
    localparam int c_CW = $clog2(SHELLS_PER_PLAYER + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   i_game_state,
    input  logic                         i_frame_tick,
    input  logic [N_PLAYERS-1:0]         i_fire,
    input  logic [N_PLAYERS*COORD_W-1:0] i_tank_x,
    input  logic [N_PLAYERS*COORD_W-1:0] i_tank_y,
    input  logic [N_PLAYERS*2-1:0]       i_tank_dir,
    input  logic [c_NS-1:0]              i_vanish,
    input  logic [c_PW-1:0]              i_rd_player,
    input  logic [c_SW-1:0]              i_rd_slot,
    output logic [c_NS-1:0]              o_valid,
    output logic [c_NS*COORD_W-1:0]      o_x,
    output logic [c_NS*COORD_W-1:0]      o_y,
    output logic [N_PLAYERS*c_CW-1:0]    o_count,
    output logic [N_PLAYERS-1:0]         o_drop,
    output logic                         o_rd_valid,
    output logic [COORD_W-1:0]           o_rd_x,
    output logic [COORD_W-1:0]           o_rd_y
);

    logic                      w_play;
    logic                      w_tick;
    logic [c_NS-1:0]           w_load;
    logic [c_NS-1:0]           w_valid_nxt;
    logic [N_PLAYERS-1:0]      w_spawn_ok;
    logic [N_PLAYERS-1:0]      w_drop_nxt;
    logic [COORD_W-1:0]        w_spawn_x [N_PLAYERS];
    logic [COORD_W-1:0]        w_spawn_y [N_PLAYERS];
    logic                      w_found;
    logic [N_PLAYERS*c_CW-1:0] w_count_nxt;
    logic                      w_rd_valid;
    logic [COORD_W-1:0]        w_rd_x;
    logic [COORD_W-1:0]        w_rd_y;

    logic [N_PLAYERS-1:0]      r_drop;
    logic [N_PLAYERS*c_CW-1:0] r_count;
    logic                      r_rd_valid;
    logic [COORD_W-1:0]        r_rd_x;
    logic [COORD_W-1:0]        r_rd_y;

    assign w_play = (i_game_state == GS_PLAY);
    assign w_tick = i_frame_tick && w_play;

    for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
        logic [COORD_W-1:0] w_tx;
        logic [COORD_W-1:0] w_ty;
        logic [1:0]         w_td;

        assign w_tx = i_tank_x[p*COORD_W +: COORD_W];
        assign w_ty = i_tank_y[p*COORD_W +: COORD_W];
        assign w_td = i_tank_dir[p*2 +: 2];

        // The spawn cell must be on the map; the tank's own cell must be too.
        assign w_spawn_ok[p] = step_ok(int'(w_tx), int'(w_ty), w_td, MAP_X_MAX, MAP_Y_MAX)
                               && (int'(w_tx) <= MAP_X_MAX) && (int'(w_ty) <= MAP_Y_MAX);
        assign w_spawn_x[p]  = COORD_W'(next_x(int'(w_tx), w_td));
        assign w_spawn_y[p]  = COORD_W'(next_y(int'(w_ty), w_td));

        for (genvar s = 0; s < SHELLS_PER_PLAYER; s++) begin : g_slot
            localparam int c_K = p * SHELLS_PER_PLAYER + s;

            shell_slot #(
                .COORD_W   (COORD_W),
                .MAP_X_MAX (MAP_X_MAX),
                .MAP_Y_MAX (MAP_Y_MAX)
            ) u_slot (
                .clk         (clk),
                .rst_n       (rst_n),
                .i_clear     (!w_play),
                .i_vanish    (i_vanish[c_K]),
                .i_load      (w_load[c_K]),
                .i_load_x    (w_spawn_x[p]),
                .i_load_y    (w_spawn_y[p]),
                .i_load_dir  (w_td),
                .i_tick      (w_tick),
                .o_valid     (o_valid[c_K]),
                .o_valid_nxt (w_valid_nxt[c_K]),
                .o_x         (o_x[c_K*COORD_W +: COORD_W]),
                .o_y         (o_y[c_K*COORD_W +: COORD_W])
            );
        end
    end

    // Lowest-free search uses registered valid, so a slot vanishing this cycle
    // cannot be handed out until the next one.
    always_comb begin
        w_load     = '0;
        w_drop_nxt = '0;
        w_found    = 1'b0;
        for (int p = 0; p < N_PLAYERS; p++) begin
            w_found = 1'b0;
            if (w_play && i_fire[p]) begin
                if (w_spawn_ok[p]) begin
                    for (int s = 0; s < SHELLS_PER_PLAYER; s++) begin
                        if (!w_found && !o_valid[p*SHELLS_PER_PLAYER + s]) begin
                            w_load[p*SHELLS_PER_PLAYER + s] = 1'b1;
                            w_found = 1'b1;
                        end
                    end
                end
                w_drop_nxt[p] = !w_found;
            end
        end
    end

    // Counting next-state valid keeps o_count aligned with o_valid.
    always_comb begin
        w_count_nxt = '0;
        for (int p = 0; p < N_PLAYERS; p++) begin
            for (int s = 0; s < SHELLS_PER_PLAYER; s++) begin
                w_count_nxt[p*c_CW +: c_CW] = w_count_nxt[p*c_CW +: c_CW]
                    + c_CW'(w_valid_nxt[p*SHELLS_PER_PLAYER + s]);
            end
        end
    end

    // Unmatched selects fall through to zero.
    always_comb begin
        w_rd_valid = 1'b0;
        w_rd_x     = '0;
        w_rd_y     = '0;
        for (int p = 0; p < N_PLAYERS; p++) begin
            for (int s = 0; s < SHELLS_PER_PLAYER; s++) begin
                if ((int'(i_rd_player) == p) && (int'(i_rd_slot) == s)) begin
                    w_rd_valid = o_valid[p*SHELLS_PER_PLAYER + s];
                    w_rd_x     = o_x[(p*SHELLS_PER_PLAYER + s)*COORD_W +: COORD_W];
                    w_rd_y     = o_y[(p*SHELLS_PER_PLAYER + s)*COORD_W +: COORD_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop     <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
            r_rd_x     <= '0;
            r_rd_y     <= '0;
        end else begin
            r_drop     <= w_drop_nxt;
            r_count    <= w_count_nxt;
            r_rd_valid <= w_rd_valid;
            r_rd_x     <= w_rd_x;
            r_rd_y     <= w_rd_y;
        end
    end

    assign o_drop     = r_drop;
    assign o_count    = r_count;
    assign o_rd_valid = r_rd_valid;
    assign o_rd_x     = r_rd_x;
    assign o_rd_y     = r_rd_y;

endmodule
`default_nettype wire

// File: tb/tb_shell_pool.sv
`default_nettype none
// ============================================================================
// Module      : tb_shell_pool
// Description : Self-checking bench for shell_pool: spawn table, directed
//               corner sequences and randomized traffic against a slot model.
// Revision    : 1.0 - initial
// ============================================================================
module tb_shell_pool;

    localparam int NP = 2;
    localparam int SP = 5;
    localparam int CW = 6;
    localparam int NS = NP * SP;
    localparam int MX = 39;
    localparam int MY = 29;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        i_game_state;
    logic              i_frame_tick;
    logic [NP-1:0]     i_fire;
    logic [NP*CW-1:0]  i_tank_x;
    logic [NP*CW-1:0]  i_tank_y;
    logic [NP*2-1:0]   i_tank_dir;
    logic [NS-1:0]     i_vanish;
    logic              i_rd_player;
    logic [2:0]        i_rd_slot;
    logic [NS-1:0]     o_valid;
    logic [NS*CW-1:0]  o_x;
    logic [NS*CW-1:0]  o_y;
    logic [NP*3-1:0]   o_count;
    logic [NP-1:0]     o_drop;
    logic              o_rd_valid;
    logic [CW-1:0]     o_rd_x;
    logic [CW-1:0]     o_rd_y;

    shell_pool #(
        .N_PLAYERS(NP), .SHELLS_PER_PLAYER(SP), .COORD_W(CW),
        .MAP_X_MAX(MX), .MAP_Y_MAX(MY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_game_state(i_game_state),
        .i_frame_tick(i_frame_tick), .i_fire(i_fire),
        .i_tank_x(i_tank_x), .i_tank_y(i_tank_y), .i_tank_dir(i_tank_dir),
        .i_vanish(i_vanish), .i_rd_player(i_rd_player), .i_rd_slot(i_rd_slot),
        .o_valid(o_valid), .o_x(o_x), .o_y(o_y), .o_count(o_count),
        .o_drop(o_drop), .o_rd_valid(o_rd_valid), .o_rd_x(o_rd_x), .o_rd_y(o_rd_y)
    );

    always #5 clk = ~clk;

    // Stimulus state (game states: 0 init, 1 play, 2 end; dirs: 0 up,1 down,2 left,3 right)
    int gs;
    bit tick;
    bit fire [NP];
    int tx [NP];
    int ty [NP];
    int td [NP];
    bit van [NS];
    int rp;
    int rs;

    // Reference model: one entry per slot
    bit m_valid [NS];
    int m_x [NS];
    int m_y [NS];
    int m_dir [NS];
    bit m_drop [NP];

    bit e_rd_v;
    bit e_rd_inr;
    int e_rd_x;
    int e_rd_y;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int x; int y; int d; bit drop; int ex; int ey;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string what, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", what, act, exp);
        end
    endtask

    task automatic drive();
        i_game_state = 2'(gs);
        i_frame_tick = tick;
        for (int p = 0; p < NP; p++) begin
            i_fire[p]           = fire[p];
            i_tank_x[p*CW +: CW] = CW'(tx[p]);
            i_tank_y[p*CW +: CW] = CW'(ty[p]);
            i_tank_dir[p*2 +: 2] = 2'(td[p]);
        end
        for (int k = 0; k < NS; k++) i_vanish[k] = van[k];
        i_rd_player = rp[0];
        i_rd_slot   = 3'(rs);
    endtask

    task automatic model_edge();
        bit nv [NS];
        int nx [NS];
        int ny [NS];
        int nd [NS];
        bit al [NS];
        for (int k = 0; k < NS; k++) begin
            nv[k] = m_valid[k]; nx[k] = m_x[k]; ny[k] = m_y[k]; nd[k] = m_dir[k]; al[k] = 0;
        end
        if (gs != 1) begin
            for (int k = 0; k < NS; k++) begin nv[k] = 0; nx[k] = 0; ny[k] = 0; nd[k] = 0; end
            for (int p = 0; p < NP; p++) m_drop[p] = 0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                m_drop[p] = 0;
                if (fire[p]) begin
                    int sx, sy, f;
                    sx = tx[p] + (td[p] == 3 ? 1 : 0) - (td[p] == 2 ? 1 : 0);
                    sy = ty[p] + (td[p] == 1 ? 1 : 0) - (td[p] == 0 ? 1 : 0);
                    if (sx < 0 || sx > MX || sy < 0 || sy > MY) m_drop[p] = 1;
                    else begin
                        f = -1;
                        for (int s = SP - 1; s >= 0; s--) if (!m_valid[p*SP+s]) f = s;
                        if (f < 0) m_drop[p] = 1;
                        else begin
                            al[p*SP+f] = 1; nx[p*SP+f] = sx; ny[p*SP+f] = sy; nd[p*SP+f] = td[p];
                        end
                    end
                end
            end
            for (int k = 0; k < NS; k++) begin
                if (van[k] && m_valid[k]) nv[k] = 0;
                else if (al[k]) nv[k] = 1;
                else if (tick && m_valid[k]) begin
                    int mx, my;
                    mx = m_x[k] + (m_dir[k] == 3 ? 1 : 0) - (m_dir[k] == 2 ? 1 : 0);
                    my = m_y[k] + (m_dir[k] == 1 ? 1 : 0) - (m_dir[k] == 0 ? 1 : 0);
                    if (mx < 0 || mx > MX || my < 0 || my > MY) nv[k] = 0;
                    else begin nx[k] = mx; ny[k] = my; end
                end
            end
        end
        for (int k = 0; k < NS; k++) begin
            m_valid[k] = nv[k]; m_x[k] = nx[k]; m_y[k] = ny[k]; m_dir[k] = nd[k];
        end
    endtask

    task automatic compare_all(input string tag);
        logic [63:0] ev, ex, ax, ey, ay;
        ev = '0; ex = '0; ax = '0; ey = '0; ay = '0;
        for (int k = 0; k < NS; k++) begin
            ev[k] = m_valid[k];
            if (m_valid[k]) begin
                ex[k*CW +: CW] = CW'(m_x[k]);  ax[k*CW +: CW] = o_x[k*CW +: CW];
                ey[k*CW +: CW] = CW'(m_y[k]);  ay[k*CW +: CW] = o_y[k*CW +: CW];
            end
        end
        chk({tag, " valid"}, 64'(o_valid), ev);
        chk({tag, " x"}, ax, ex);
        chk({tag, " y"}, ay, ey);
        for (int p = 0; p < NP; p++) begin
            int c;
            c = 0;
            for (int s = 0; s < SP; s++) c += m_valid[p*SP+s] ? 1 : 0;
            chk($sformatf("%s count%0d", tag, p), 64'(o_count[p*3 +: 3]), 64'(c));
            chk($sformatf("%s drop%0d", tag, p), 64'(o_drop[p]), 64'(m_drop[p]));
        end
        chk({tag, " rd_valid"}, 64'(o_rd_valid), 64'(e_rd_v));
        if (e_rd_v || !e_rd_inr) begin
            chk({tag, " rd_x"}, 64'(o_rd_x), 64'(e_rd_x));
            chk({tag, " rd_y"}, 64'(o_rd_y), 64'(e_rd_y));
        end
    endtask

    task automatic step(input string tag);
        drive();
        // Read data reflects slot state as it stands when the select is sampled.
        e_rd_inr = (rp < NP) && (rs < SP);
        e_rd_v = 0; e_rd_x = 0; e_rd_y = 0;
        if (e_rd_inr) begin
            e_rd_v = m_valid[rp*SP+rs]; e_rd_x = m_x[rp*SP+rs]; e_rd_y = m_y[rp*SP+rs];
        end
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
        tick = 0;
        for (int p = 0; p < NP; p++) fire[p] = 0;
        for (int k = 0; k < NS; k++) van[k] = 0;
    endtask

    initial begin
        tbl[0] = '{5, 10, 3, 0, 6, 10};
        tbl[1] = '{5, 10, 0, 0, 5, 9};
        tbl[2] = '{5, 10, 1, 0, 5, 11};
        tbl[3] = '{5, 10, 2, 0, 4, 10};
        tbl[4] = '{0, 3, 2, 1, 0, 0};
        tbl[5] = '{39, 3, 3, 1, 0, 0};
        tbl[6] = '{7, 0, 0, 1, 0, 0};
        tbl[7] = '{7, 29, 1, 1, 0, 0};
        tbl[8] = '{38, 29, 3, 0, 39, 29};
        tbl[9] = '{0, 0, 1, 0, 0, 1};

        gs = 1; tick = 0; rp = 0; rs = 0;
        for (int p = 0; p < NP; p++) begin fire[p] = 0; tx[p] = 0; ty[p] = 0; td[p] = 0; m_drop[p] = 0; end
        for (int k = 0; k < NS; k++) begin van[k] = 0; m_valid[k] = 0; m_x[k] = 0; m_y[k] = 0; m_dir[k] = 0; end
        rst_n = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("reset valid", 64'(o_valid), 64'd0);
        chk("reset x", 64'(o_x), 64'd0);
        chk("reset y", 64'(o_y), 64'd0);
        chk("reset count", 64'(o_count), 64'd0);
        chk("reset drop", 64'(o_drop), 64'd0);
        chk("reset rd", {o_rd_valid, o_rd_x, o_rd_y}, 64'd0);

        // Spawn table
        for (int i = 0; i < 10; i++) begin
            gs = 2; step("tbl_clear");
            gs = 1;
            tx[0] = tbl[i].x; ty[0] = tbl[i].y; td[0] = tbl[i].d; fire[0] = 1;
            step("tbl_fire");
            chk($sformatf("tbl%0d drop", i), 64'(o_drop[0]), 64'(tbl[i].drop));
            chk($sformatf("tbl%0d valid", i), 64'(o_valid[0]), 64'(!tbl[i].drop));
            if (!tbl[i].drop) begin
                chk($sformatf("tbl%0d x", i), 64'(o_x[5:0]), 64'(tbl[i].ex));
                chk($sformatf("tbl%0d y", i), 64'(o_y[5:0]), 64'(tbl[i].ey));
            end
        end

        // Fill player 0, overflow, then vanish+fire in the same cycle
        gs = 2; step("fill_clear"); gs = 1;
        tx[0] = 5; ty[0] = 10; td[0] = 3;
        for (int i = 0; i < 5; i++) begin fire[0] = 1; step("fill"); end
        chk("fill count0", 64'(o_count[2:0]), 64'd5);
        chk("fill valid", 64'(o_valid[4:0]), 64'h1f);
        fire[0] = 1; step("overflow");
        chk("overflow drop0", 64'(o_drop[0]), 64'd1);
        chk("overflow count0", 64'(o_count[2:0]), 64'd5);
        step("overflow_idle");
        chk("drop pulse end", 64'(o_drop[0]), 64'd0);
        van[2] = 1; fire[0] = 1; step("vanish_fire");
        chk("vanish_fire drop0", 64'(o_drop[0]), 64'd1);
        chk("vanish_fire valid", 64'(o_valid[4:0]), 64'h1b);
        fire[0] = 1; step("refire");
        chk("refire valid", 64'(o_valid[4:0]), 64'h1f);
        chk("refire slot2 x", 64'(o_x[17:12]), 64'd6);

        // Right-edge exit: coordinates hold
        gs = 2; step("edge_clear"); gs = 1;
        tx[0] = 37; ty[0] = 4; td[0] = 3; fire[0] = 1; step("edge_fire");
        chk("edge spawn x", 64'(o_x[5:0]), 64'd38);
        tick = 1; step("edge_tick1");
        chk("edge x39", 64'(o_x[5:0]), 64'd39);
        chk("edge still valid", 64'(o_valid[0]), 64'd1);
        tick = 1; step("edge_tick2");
        chk("edge freed", 64'(o_valid[0]), 64'd0);
        chk("edge x held", 64'(o_x[5:0]), 64'd39);

        // Fire+tick same cycle, read-port latency, end of game
        gs = 2; step("ft_clear"); gs = 1;
        tx[0] = 10; ty[0] = 10; td[0] = 0; fire[0] = 1; tick = 1; step("fire_tick");
        chk("fire_tick y", 64'(o_y[5:0]), 64'd9);
        chk("fire_tick x", 64'(o_x[5:0]), 64'd10);
        tx[1] = 20; ty[1] = 20; td[1] = 1; fire[1] = 1; step("p1_fire");
        rp = 1; rs = 0; step("rd_sel");
        chk("rd p1s0 valid", 64'(o_rd_valid), 64'd1);
        chk("rd p1s0 x", 64'(o_rd_x), 64'd20);
        chk("rd p1s0 y", 64'(o_rd_y), 64'd21);
        rs = 7; step("rd_oob");
        chk("rd oob", {o_rd_valid, o_rd_x, o_rd_y}, 64'd0);
        gs = 2; step("game_end");
        chk("end valid", 64'(o_valid), 64'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 29);
            gs = (r == 0) ? 2 : ((r == 1) ? 0 : 1);
            tick = ($urandom_range(0, 3) == 0);
            for (int p = 0; p < NP; p++) begin
                fire[p] = ($urandom_range(0, 2) == 0);
                tx[p] = $urandom_range(0, MX);
                ty[p] = $urandom_range(0, MY);
                td[p] = $urandom_range(0, 3);
            end
            for (int k = 0; k < NS; k++) van[k] = ($urandom_range(0, 11) == 0);
            rp = $urandom_range(0, 1);
            rs = $urandom_range(0, 7);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shell_pool.md
Name: shell_pool

Overview:
- Parametrised shell store and mover for the tank game.
- Replaces the fixed 2-player × 5-shell arrangement with N_PLAYERS × SHELLS_PER_PLAYER slots.
- Allocates a slot on each player's fire pulse, advances every live shell one grid cell per frame tick, and frees shells on edge exit or external vanish.
- Exposes flat position/valid buses for collision logic and a registered random-access read port for the VGA renderer.

Parameters:
- N_PLAYERS, 2, number of tanks/players.
- SHELLS_PER_PLAYER, 5, slots per player.
- COORD_W, 6, grid coordinate width.
- MAP_X_MAX, 39, largest legal x cell.
- MAP_Y_MAX, 29, largest legal y cell.

Ports:
- clk  in  1  system clock (25 MHz domain)
- rst_n  in  1  asynchronous active-low reset
- i_game_state  in  2  top game state
- i_frame_tick  in  1  one-cycle move strobe
- i_fire  in  N_PLAYERS  one-cycle fire request per player
- i_tank_x  in  N_PLAYERS*COORD_W  tank x, player p at [p*COORD_W +: COORD_W]
- i_tank_y  in  N_PLAYERS*COORD_W  tank y, same packing
- i_tank_dir  in  N_PLAYERS*2  tank direction
- i_vanish  in  N_PLAYERS*SHELLS_PER_PLAYER  free slot k (k = p*SHELLS_PER_PLAYER + s)
- i_rd_player  in  $clog2(N_PLAYERS)  read-port player select
- i_rd_slot  in  $clog2(SHELLS_PER_PLAYER)  read-port slot select
- o_valid  out  N_PLAYERS*SHELLS_PER_PLAYER  slot live bitmap
- o_x  out  N_PLAYERS*SHELLS_PER_PLAYER*COORD_W  slot x, flat
- o_y  out  N_PLAYERS*SHELLS_PER_PLAYER*COORD_W  slot y, flat
- o_count  out  N_PLAYERS*$clog2(SHELLS_PER_PLAYER+1)  live shells per player
- o_drop  out  N_PLAYERS  one-cycle pulse: fire rejected
- o_rd_valid  out  1  read-port valid, 1-cycle latency
- o_rd_x  out  COORD_W  read-port x, 1-cycle latency
- o_rd_y  out  COORD_W  read-port y, 1-cycle latency

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all o_valid, o_x, o_y, o_count, o_drop, o_rd_* = 0. Stored directions = DIR_UP.
- Direction encoding: 0 up (y-1), 1 down (y+1), 2 left (x-1), 3 right (x+1).
- Inactive game state: when i_game_state != GS_PLAY, every slot is cleared synchronously and fire/tick are ignored. o_drop stays 0.
- Spawn position: tank position plus one step in the tank direction. If that step leaves 0..MAP_X_MAX / 0..MAP_Y_MAX, the request is dropped (o_drop[p]=1 next cycle).
- Allocation:
  - On i_fire[p], take the lowest-index slot of player p whose registered valid=0 at that cycle.
  - Store spawn x/y and the direction.
  - The slot becomes valid on the next cycle.
  - Slots freed in the same cycle are not reusable until the following cycle.
  - If no free slot exists, o_drop[p] pulses for 1 cycle and state is unchanged.
- Move: on i_frame_tick, every valid slot steps one cell in its direction.
  - If the step would cross a bound (x==0 left, x==MAX_X right, y==0 up, y==MAX_Y down), the slot is freed instead; its coordinates hold their last value.
  - No wrap-around ever occurs.
- Priority per slot, same cycle: vanish > allocate > move.
  - A slot allocated this cycle is not moved by a simultaneous tick.
  - i_vanish on an already-invalid slot is a no-op.
  - A simultaneous vanish and fire never target the same slot, because allocation uses registered valid.
- Player independence: fires from different players in the same cycle are independent.
- o_count: registered popcount of each player's o_valid; it updates in the same cycle as o_valid.
- Read port:
  - o_rd_* is registered from the selected slot one cycle after the select is presented.
  - Out-of-range select returns valid=0, x=0, y=0.
- Edge detection: i_fire is treated as a pulse. No edge detection is done in this block.

Decomposition:
- tank_pkg holds:
  - dir_t enum (DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3).
  - game-state constants GS_INIT/GS_PLAY/GS_END.
  - A step_ok/next_pos function shared with tank.
- Sub-module shell_slot: one slot's valid/x/y/dir registers plus the vanish/load/move/out-of-bounds logic. It is generated N_PLAYERS*SHELLS_PER_PLAYER times.
- shell_pool keeps the lowest-free priority encoder, drop/count logic and read mux.

Test Plan:
- Reset with game state GS_PLAY → all outputs 0. Tank0 at (5,10) dir right, fire pulse → next cycle slot0 valid, x=6, y=10, o_count[0]=1.
- 6 fires for player0 with default params → slots 0..4 valid, 6th fire gives o_drop[0]=1 for 1 cycle, o_count[0]=5.
- Shell at x=38 dir right: tick → x=39; tick → o_valid bit cleared, x stays 39.
- Tank at (0,3) dir left, fire → o_drop pulse, no slot valid.
- Player0 full, then i_vanish slot2 together with a fire → fire dropped. Fire next cycle → slot2 reallocated.
- Fire and tick in same cycle → new shell sits at spawn cell, not advanced. Then i_game_state→GS_END → all valid 0 next cycle. rd_player=1, rd_slot=0 → data on o_rd_* exactly 1 cycle later.
